// File: rtl/delta_codec_pkg.sv
`default_nettype none
// ============================================================================
// Module  : delta_codec_pkg
// Brief   : State encoding, default widths and saturation bounds shared by the
//           delta encoder and decoder.
// Rev     : 1.0
// ============================================================================
package delta_codec_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int c_DATA_W_DEF = 16;
   localparam int c_CNT_W_DEF  = 5;
   localparam int c_THR_W_DEF  = 11;
   localparam int c_LEN_W_DEF  = 16;

   localparam int c_SAT_MAX = (1 << (c_DATA_W_DEF - 1)) - 1;
   localparam int c_SAT_MIN = -(1 << (c_DATA_W_DEF - 1));

endpackage
`default_nettype wire

// File: rtl/delta_decoding_step_mul.sv
`default_nettype none
// ============================================================================
// Module  : delta_decoding_step_mul
// Brief   : Signed spike count times unsigned threshold, truncated to DATA_W.
// Rev     : 1.0
// ============================================================================
module delta_decoding_step_mul
   import delta_codec_pkg::*;
#(
   parameter int DATA_W = c_DATA_W_DEF,
   parameter int CNT_W  = c_CNT_W_DEF,
   parameter int THR_W  = c_THR_W_DEF
)(
   input  logic signed [CNT_W-1:0]  i_count,
   input  logic        [THR_W-1:0]  i_threshold,
   output logic signed [DATA_W-1:0] o_product
);

   logic signed [DATA_W-1:0] w_count_ext;
   logic signed [DATA_W-1:0] w_thr_ext;

   // Low DATA_W bits of a product only depend on the low DATA_W bits of the
   // operands, so extending both to DATA_W yields the truncated product.
   assign w_count_ext = DATA_W'(i_count);
   assign w_thr_ext   = $signed(DATA_W'(i_threshold));
   assign o_product   = w_count_ext * w_thr_ext;

endmodule
`default_nettype wire

// File: rtl/delta_decoding.sv
`default_nettype none
// ============================================================================
// Module  : delta_decoding
// Brief   : Rebuilds a saturated signed sample stream from delta-spike counts.
// Rev     : 1.0
// ============================================================================
module delta_decoding
   import delta_codec_pkg::*;
#(
   parameter int DATA_W = c_DATA_W_DEF,
   parameter int CNT_W  = c_CNT_W_DEF,
   parameter int THR_W  = c_THR_W_DEF,
   parameter int LEN_W  = c_LEN_W_DEF
)(
   input  logic                     ap_clk,
   input  logic                     ap_rst,
   input  logic                     ap_start,
   input  logic        [THR_W-1:0]  cfg_threshold,
   input  logic signed [DATA_W-1:0] cfg_init,
   input  logic        [LEN_W-1:0]  cfg_len,
   input  logic signed [CNT_W-1:0]  s_tdata,
   input  logic                     s_tvalid,
   output logic                     s_tready,
   output logic signed [DATA_W-1:0] m_tdata,
   output logic                     m_tvalid,
   input  logic                     m_tready,
   output logic                     ap_idle,
   output logic                     ap_done
);

   localparam logic [DATA_W-1:0] c_SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] c_SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   state_t              r_state;
   state_t              w_state_next;
   logic [THR_W-1:0]    r_thr;
   logic [DATA_W-1:0]   r_acc;
   logic [LEN_W-1:0]    r_remaining;
   logic [DATA_W-1:0]   r_m_tdata;
   logic                r_m_tvalid;

   logic signed [DATA_W-1:0] w_prod;
   logic [DATA_W:0]          w_sum;
   logic [DATA_W-1:0]        w_acc_next;
   logic                     w_s_tready;
   logic                     w_accept;

   delta_decoding_step_mul #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W),
      .THR_W  (THR_W)
   ) u_step_mul (
      .i_count     (s_tdata),
      .i_threshold (r_thr),
      .o_product   (w_prod)
   );

   assign w_s_tready = (r_state == S_RUN) && (r_remaining != '0)
                       && (!r_m_tvalid || m_tready);
   assign w_accept   = s_tvalid && w_s_tready;

   // One guard bit: disagreement between the top two bits flags overflow.
   assign w_sum = {r_acc[DATA_W-1], r_acc} + {w_prod[DATA_W-1], w_prod};

   always_comb begin
      w_acc_next = w_sum[DATA_W-1:0];
      if (w_sum[DATA_W] != w_sum[DATA_W-1]) begin
         w_acc_next = w_sum[DATA_W] ? c_SAT_MIN : c_SAT_MAX;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (ap_start) begin
               w_state_next = (cfg_len == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if ((r_remaining == '0) && !r_m_tvalid) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_thr       <= '0;
         r_acc       <= '0;
         r_remaining <= '0;
         r_m_tdata   <= '0;
         r_m_tvalid  <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && ap_start) begin
            r_thr       <= cfg_threshold;
            r_acc       <= cfg_init;
            r_remaining <= cfg_len;
         end
         if (w_accept) begin
            r_acc       <= w_acc_next;
            r_m_tdata   <= w_acc_next;
            r_m_tvalid  <= 1'b1;
            r_remaining <= r_remaining - LEN_W'(1);
         end else if (r_m_tvalid && m_tready) begin
            r_m_tvalid  <= 1'b0;
         end
      end
   end

   assign s_tready = w_s_tready;
   assign m_tdata  = r_m_tdata;
   assign m_tvalid = r_m_tvalid;
   assign ap_idle  = (r_state == S_IDLE);
   assign ap_done  = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: doc/delta_decoding.md
DELTA_DECODING -- requirements
Module: delta_decoding

Interface
REQ-001 Parameter DATA_W, default 16: width of the reconstructed signed sample.
REQ-002 Parameter CNT_W, default 5: width of the signed delta-spike count.
REQ-003 Parameter THR_W, default 11: width of the unsigned encoding threshold.
REQ-004 Parameter LEN_W, default 16: width of the sample-count register.
REQ-005 Port ap_clk, input, 1: the single clock; all logic is clocked on its rising edge.
REQ-006 Port ap_rst, input, 1: synchronous, active-high reset.
REQ-007 Port ap_start, input, 1: start pulse; sampled only in IDLE.
REQ-008 Port cfg_threshold, input, THR_W: delta step per unit of count; captured at start.
REQ-009 Port cfg_init, input, DATA_W signed: initial reconstruction value; captured at start.
REQ-010 Port cfg_len, input, LEN_W: number of spike words to decode; captured at start.
REQ-011 Port s_tdata, input, CNT_W signed: spike count; positive is UP, negative is DOWN, zero is no spike.
REQ-012 Port s_tvalid / s_tready, input / output, 1 each: spike stream handshake.
REQ-013 Port m_tdata, output, DATA_W signed: reconstructed sample.
REQ-014 Port m_tvalid / m_tready, output / input, 1 each: sample stream handshake.
REQ-015 Port ap_idle, output, 1: high in IDLE.
REQ-016 Port ap_done, output, 1: one-cycle pulse at the end of a run.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-018 IDLE with ap_start=1 SHALL capture the configuration and go to RUN; if cfg_len=0 it SHALL go directly to DONE instead.
REQ-019 RUN SHALL go to DONE in the cycle after the final output is accepted, i.e. when remaining=0 and m_tvalid=0.
REQ-020 DONE SHALL assert ap_done for one cycle and then return to IDLE.
REQ-021 A spike is accepted when s_tvalid and s_tready are both high.
REQ-022 s_tready SHALL equal (state==RUN) AND (remaining>0) AND (m_tvalid=0 OR m_tready=1).
REQ-023 On acceptance, the block SHALL compute acc_next = sat(acc + s_tdata*threshold).
REQ-024 The product SHALL be a signed CNT_W by unsigned THR_W multiply with a DATA_W-bit signed result.
REQ-025 The sum SHALL be formed at DATA_W+1 bits and saturated to the DATA_W signed range, for example [-32768, 32767].
REQ-026 acc_next SHALL be registered into both the accumulator and m_tdata, and m_tvalid SHALL be set; latency is 1 cycle from acceptance to m_tvalid.
REQ-027 m_tdata and m_tvalid SHALL hold stable while m_tvalid=1 and m_tready=0.
REQ-028 When m_tvalid=1 and m_tready=1 with no new acceptance, m_tvalid SHALL clear.
REQ-029 When an output is consumed and a new spike is accepted in the same cycle, m_tvalid SHALL stay high and m_tdata SHALL update; full throughput is 1 sample per cycle.
REQ-030 remaining SHALL decrement by exactly one per acceptance and SHALL never wrap below zero.
REQ-031 ap_start SHALL be ignored outside IDLE, and configuration inputs SHALL be ignored after capture.
REQ-032 A count of zero SHALL still produce an output sample equal to the current accumulator.

Reset
REQ-033 While ap_rst=1 at a clock edge, the block SHALL set state=IDLE, acc=0, remaining=0, m_tdata=0, m_tvalid=0, ap_done=0, ap_idle=1 and s_tready=0.
REQ-034 Reset asserted mid-run SHALL abort the run with no ap_done pulse; any pending output SHALL be dropped.

Structure
REQ-035 A package delta_codec_pkg SHALL hold the state enum, the default widths and the saturation bounds, and SHALL be shared with the encoder.
REQ-036 The multiply SHALL be placed in one combinational sub-module, delta_decoding_step_mul, with signed CNT_W by unsigned THR_W inputs and a DATA_W-bit output.

Verification
REQ-037 The bench SHALL cover: init=0, thr=100, len=3, counts +1,+2,-3 with m_tready=1 -> outputs 100, 300, 0 on consecutive cycles, then ap_done 1 cycle after the last output.
REQ-038 The bench SHALL cover: init=32700, thr=2047, count +15 -> output 32767; then count -16 -> output 32767-32752 = 15.
REQ-039 The bench SHALL cover: init=-32768, thr=2047, count -16 -> output -32768, saturated low.
REQ-040 The bench SHALL cover: m_tready held low for 3 cycles with s_tvalid=1 -> s_tready=0 and m_tdata held stable, then resume with no loss or duplication of samples.
REQ-041 The bench SHALL cover: ap_start with cfg_len=0 -> no m_tvalid and ap_done asserted 2 cycles after start.
REQ-042 The bench SHALL cover: ap_rst asserted after 2 of 5 spikes -> next cycle all outputs equal reset values, no ap_done, and a new run decodes from its own cfg_init.
